// File: rtl/uart_wb_host_bridge.sv
// UART (8N1) command frames to single pipelined Wishbone transfers; status/read data returned over UART.
// Optional trailing XOR checksum byte when CORTEZ_UART_CSUM_EN is defined.
module uart_wb_host_bridge #(
    parameter int CLKS_PER_BIT   = 868,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  UART_RX,
    output logic                  UART_TX,
    output logic                  WB_CYC,
    output logic                  WB_STB,
    output logic                  WB_WE,
    output logic [ADDR_WIDTH-1:0] WB_ADDR,
    output logic [DATA_WIDTH-1:0] WB_WDATA,
    output logic                  WB_SEL,
    input  logic                  WB_STALL,
    input  logic                  WB_ACK,
    input  logic [DATA_WIDTH-1:0] WB_RDATA,
    input  logic                  WB_ERR,
    output logic                  BUSY
);
    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_M1  = CW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] TMO_M1  = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_DATA, S_CSUM, S_BUS_REQ, S_BUS_WAIT, S_RESP_STAT, S_RESP_DATA
    } state_t;

`ifdef CORTEZ_UART_CSUM_EN
    localparam state_t FRAME_END = S_CSUM;
`else
    localparam state_t FRAME_END = S_BUS_REQ;
`endif

    state_t state, next_state;

    logic           rx_m, rx_s, rx_prev, rx_busy, rx_vld, rx_ferr;
    logic [CW-1:0]  rx_cnt;
    logic [3:0]     rx_bit;
    logic [7:0]     rx_sh;

    // Bit 0 is the start bit re-checked at half-bit; bit 9 is the stop bit.
    always_ff @(posedge CLK) begin
        if (RST) begin
            rx_m    <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
            rx_busy <= 1'b0;
            rx_cnt  <= '0;
            rx_bit  <= '0;
            rx_sh   <= '0;
            rx_vld  <= 1'b0;
            rx_ferr <= 1'b0;
        end else begin
            rx_m    <= UART_RX;
            rx_s    <= rx_m;
            rx_prev <= rx_s;
            rx_vld  <= 1'b0;
            rx_ferr <= 1'b0;
            if (!rx_busy) begin
                if (rx_prev && !rx_s) begin
                    rx_busy <= 1'b1;
                    rx_cnt  <= '0;
                    rx_bit  <= '0;
                end
            end else if (rx_cnt == ((rx_bit == 4'd0) ? HALF_M1 : BIT_M1)) begin
                rx_cnt <= '0;
                rx_bit <= rx_bit + 4'd1;
                if (rx_bit == 4'd0) begin
                    if (rx_s) rx_busy <= 1'b0;
                end else if (rx_bit == 4'd9) begin
                    rx_busy <= 1'b0;
                    rx_vld  <= rx_s;
                    rx_ferr <= !rx_s;
                end else begin
                    rx_sh <= {rx_s, rx_sh[7:1]};
                end
            end else begin
                rx_cnt <= rx_cnt + CW'(1);
            end
        end
    end

    logic [9:0]     tx_sh;
    logic [3:0]     tx_left;
    logic [CW-1:0]  tx_cnt;
    logic           tx_go, tx_rdy;
    logic [7:0]     tx_dat;

    // Accepting a new byte in the last stop-bit cycle keeps consecutive bytes gap-free.
    assign tx_rdy  = (tx_left == 4'd0) || (tx_left == 4'd1 && tx_cnt == BIT_M1);
    assign UART_TX = (tx_left == 4'd0) ? 1'b1 : tx_sh[0];

    always_ff @(posedge CLK) begin
        if (RST) begin
            tx_sh   <= '1;
            tx_left <= '0;
            tx_cnt  <= '0;
        end else if (tx_go && tx_rdy) begin
            tx_sh   <= {1'b1, tx_dat, 1'b0};
            tx_left <= 4'd10;
            tx_cnt  <= '0;
        end else if (tx_left != 4'd0) begin
            if (tx_cnt == BIT_M1) begin
                tx_cnt  <= '0;
                tx_left <= tx_left - 4'd1;
                tx_sh   <= {1'b1, tx_sh[9:1]};
            end else begin
                tx_cnt <= tx_cnt + CW'(1);
            end
        end
    end

    logic                  is_wr, ok;
    logic [1:0]            byte_cnt;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata, rdata;
    logic [TW-1:0]         tmr;
    logic                  in_bus, bus_done, tmo;
`ifdef CORTEZ_UART_CSUM_EN
    logic [7:0]            csum;
`endif

    assign in_bus   = (state == S_BUS_REQ) || (state == S_BUS_WAIT);
    assign bus_done = WB_ACK || WB_ERR;
    assign tmo      = (tmr == TMO_M1);

    always_ff @(posedge CLK) begin
        if (RST) begin
            is_wr    <= 1'b0;
            ok       <= 1'b0;
            byte_cnt <= '0;
            addr     <= '0;
            wdata    <= '0;
            rdata    <= '0;
            tmr      <= '0;
`ifdef CORTEZ_UART_CSUM_EN
            csum     <= '0;
`endif
        end else begin
            tmr <= in_bus ? tmr + TW'(1) : '0;
            if (rx_vld) begin
                case (state)
                    S_IDLE: begin
                        is_wr    <= (rx_sh == 8'h57);
                        ok       <= 1'b0;
                        byte_cnt <= '0;
                    end
                    S_ADDR: begin
                        addr     <= {addr[ADDR_WIDTH-9:0], rx_sh};
                        byte_cnt <= byte_cnt + 2'd1;
                    end
                    S_DATA:  wdata <= rx_sh;
                    default: ;
                endcase
`ifdef CORTEZ_UART_CSUM_EN
                if (state == S_IDLE) csum <= rx_sh;
                else if (state == S_ADDR || state == S_DATA) csum <= csum ^ rx_sh;
`endif
            end
            // ERR has priority; a timeout leaves ok cleared.
            if (in_bus && bus_done) begin
                ok <= !WB_ERR;
                if (!WB_ERR) rdata <= WB_RDATA;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) state <= S_IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        tx_go      = 1'b0;
        tx_dat     = 8'h15;
        case (state)
            S_IDLE:
                if (rx_vld) next_state = (rx_sh == 8'h57 || rx_sh == 8'h52) ? S_ADDR : S_RESP_STAT;
            S_ADDR:
                if (rx_vld && byte_cnt == 2'd3) next_state = is_wr ? S_DATA : FRAME_END;
            S_DATA:
                if (rx_vld) next_state = FRAME_END;
`ifdef CORTEZ_UART_CSUM_EN
            S_CSUM:
                if (rx_vld) next_state = (rx_sh == csum) ? S_BUS_REQ : S_RESP_STAT;
`endif
            S_BUS_REQ:
                if (bus_done || tmo) next_state = S_RESP_STAT;
                else if (!WB_STALL)  next_state = S_BUS_WAIT;
            S_BUS_WAIT:
                if (bus_done || tmo) next_state = S_RESP_STAT;
            S_RESP_STAT: begin
                tx_go  = 1'b1;
                tx_dat = ok ? 8'h06 : 8'h15;
                if (tx_rdy) next_state = (ok && !is_wr) ? S_RESP_DATA : S_IDLE;
            end
            S_RESP_DATA: begin
                tx_go  = 1'b1;
                tx_dat = rdata;
                if (tx_rdy) next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
        if (rx_ferr && (state == S_IDLE || state == S_ADDR || state == S_DATA || state == S_CSUM))
            next_state = S_IDLE;
    end

    assign WB_CYC   = in_bus;
    assign WB_STB   = (state == S_BUS_REQ);
    assign WB_WE    = in_bus && is_wr;
    assign WB_SEL   = in_bus;
    assign WB_ADDR  = addr;
    assign WB_WDATA = wdata;
    assign BUSY     = (state != S_IDLE);

endmodule

// File: tb/tb_uart_wb_host_bridge.sv
// Bench for uart_wb_host_bridge: directed vector table plus random frames against a frame-level model.
module tb_uart_wb_host_bridge;
    localparam int CPB = 16;
    localparam int TMO = 40;
    localparam int M_ACK = 0, M_ERR = 1, M_BOTH = 2, M_NONE = 3;

    logic        CLK, RST, UART_RX, UART_TX;
    logic        WB_CYC, WB_STB, WB_WE, WB_SEL, WB_STALL, WB_ACK, WB_ERR, BUSY;
    logic [31:0] WB_ADDR;
    logic [7:0]  WB_WDATA, WB_RDATA;

    uart_wb_host_bridge #(.CLKS_PER_BIT(CPB), .ADDR_WIDTH(32), .DATA_WIDTH(8), .TIMEOUT_CYCLES(TMO)) dut (
        .CLK(CLK), .RST(RST), .UART_RX(UART_RX), .UART_TX(UART_TX),
        .WB_CYC(WB_CYC), .WB_STB(WB_STB), .WB_WE(WB_WE), .WB_ADDR(WB_ADDR),
        .WB_WDATA(WB_WDATA), .WB_SEL(WB_SEL), .WB_STALL(WB_STALL), .WB_ACK(WB_ACK),
        .WB_RDATA(WB_RDATA), .WB_ERR(WB_ERR), .BUSY(BUSY)
    );

    typedef struct {
        logic [7:0]  cmd;
        logic [31:0] addr;
        logic [7:0]  wdata;
        int          stall;
        int          resp_at;
        int          mode;
        logic [7:0]  rdata;
        bit          late;
        bit          bad_csum;
    } vec_t;

    int n_vec = 0, n_err = 0;

    int          s_stall = 0, s_resp_at = 0, s_mode = M_NONE;
    logic [7:0]  s_rdata = 0;
    bit          s_late = 0;
    int          k, late_cnt;
    int          cyc_seen, cyc_cnt, stb_cnt, sel_bad;
    logic [31:0] cap_addr;
    logic        cap_we;
    logic [7:0]  cap_wdata;
    logic [8:0]  tx_q[$];

    initial begin
        CLK = 0;
        forever #5 CLK = ~CLK;
    end

    // Slave: counts cycles from first STB, stalls/answers at configured offsets, records the transfer.
    initial begin
        bit resp;
        k = -1; late_cnt = -1;
        cyc_seen = 0; cyc_cnt = 0; stb_cnt = 0; sel_bad = 0;
        cap_addr = 0; cap_we = 0; cap_wdata = 0;
        WB_STALL = 0; WB_ACK = 0; WB_ERR = 0; WB_RDATA = 0;
        forever begin
            @(posedge CLK); #1;
            if (WB_CYC) begin
                if (k < 0) begin
                    k = 0; cyc_seen++;
                    cap_addr = WB_ADDR; cap_we = WB_WE; cap_wdata = WB_WDATA;
                end else k++;
                cyc_cnt++;
                if (WB_STB) stb_cnt++;
                if (!WB_SEL) sel_bad++;
            end else begin
                if (k >= 0 && s_late) late_cnt = 3;
                k = -1;
            end
            resp     = WB_CYC && (k == s_resp_at) && (s_mode != M_NONE);
            WB_STALL = WB_CYC && (k < s_stall);
            WB_ACK   = (resp && s_mode != M_ERR) || (late_cnt == 0);
            WB_ERR   = resp && s_mode != M_ACK;
            WB_RDATA = resp ? s_rdata : 8'($urandom);
            if (late_cnt >= 0) late_cnt--;
        end
    end

    // UART receiver on the DUT's TX line; stores {stop bit, data}.
    initial begin
        logic [7:0] b;
        forever begin
            @(negedge CLK);
            if (UART_TX === 1'b0) begin
                repeat (CPB / 2) @(negedge CLK);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge CLK);
                    b[i] = UART_TX;
                end
                repeat (CPB) @(negedge CLK);
                tx_q.push_back({UART_TX, b});
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        @(negedge CLK); UART_RX = 1'b0;
        repeat (CPB) @(negedge CLK);
        for (int i = 0; i < 8; i++) begin
            UART_RX = b[i];
            repeat (CPB) @(negedge CLK);
        end
        UART_RX = stop;
        repeat (CPB) @(negedge CLK);
        UART_RX = 1'b1;
    endtask

    task automatic clear_mon(input vec_t v);
        s_stall = v.stall; s_resp_at = v.resp_at; s_mode = v.mode;
        s_rdata = v.rdata; s_late = v.late;
        cyc_seen = 0; cyc_cnt = 0; stb_cnt = 0; sel_bad = 0;
        tx_q.delete();
    endtask

    function automatic vec_t mk(input logic [7:0] cmd, input logic [31:0] addr, input logic [7:0] wd,
                                input int stall, input int resp_at, input int mode,
                                input logic [7:0] rd, input bit late, input bit bad_csum);
        vec_t v;
        v.cmd = cmd; v.addr = addr; v.wdata = wd; v.stall = stall; v.resp_at = resp_at;
        v.mode = mode; v.rdata = rd; v.late = late; v.bad_csum = bad_csum;
        return v;
    endfunction

    // Frame-level model: expected reply bytes and bus transfer shape from the command rules.
    task automatic run_vec(input vec_t v);
        logic [7:0] fr[$];
        logic [7:0] exq[$];
        logic [7:0] x;
        bit         valid, cs_ok, tmo_hit;
        int         ecyc, ecnt, estb, w;
        valid = (v.cmd == 8'h57) || (v.cmd == 8'h52);
        cs_ok = 1;
        fr.push_back(v.cmd);
        if (valid) begin
            for (int b = 3; b >= 0; b--) fr.push_back(v.addr[8*b +: 8]);
            if (v.cmd == 8'h57) fr.push_back(v.wdata);
`ifdef CORTEZ_UART_CSUM_EN
            x = 8'h00;
            foreach (fr[j]) x = x ^ fr[j];
            fr.push_back(v.bad_csum ? ~x : x);
            cs_ok = !v.bad_csum;
`endif
        end
        ecyc = 0; ecnt = 0; estb = 0;
        if (!valid || !cs_ok) begin
            exq.push_back(8'h15);
        end else begin
            ecyc = 1;
            tmo_hit = (v.mode == M_NONE) || (v.resp_at >= TMO);
            if (tmo_hit) begin
                ecnt = TMO;
                estb = ((v.stall < TMO - 1) ? v.stall : TMO - 1) + 1;
                exq.push_back(8'h15);
            end else begin
                ecnt = v.resp_at + 1;
                estb = ((v.stall < v.resp_at) ? v.stall : v.resp_at) + 1;
                if (v.mode == M_ACK) begin
                    exq.push_back(8'h06);
                    if (v.cmd == 8'h52) exq.push_back(v.rdata);
                end else exq.push_back(8'h15);
            end
        end
        clear_mon(v);
        foreach (fr[j]) send_byte(fr[j], 1'b1);
        for (w = 0; w < 4000 && !(tx_q.size() >= exq.size() && !BUSY); w++) @(negedge CLK);
        check("resp_wait", 32'(w < 4000), 1);
        repeat (12 * CPB) @(negedge CLK);
        check("tx_count", tx_q.size(), exq.size());
        for (int i = 0; i < tx_q.size() && i < exq.size(); i++)
            check("tx_byte", tx_q[i], {1'b1, exq[i]});
        check("cyc_seen", cyc_seen, ecyc);
        if (ecyc != 0) begin
            check("addr", cap_addr, v.addr);
            check("we", cap_we, v.cmd == 8'h57);
            if (v.cmd == 8'h57) check("wdata", cap_wdata, v.wdata);
            check("cyc_cycles", cyc_cnt, ecnt);
            check("stb_cycles", stb_cnt, estb);
            check("sel", sel_bad, 0);
        end
    endtask

    vec_t tbl[10];
    vec_t v;

    initial begin
        int w, lows;
        tbl[0] = mk(8'h57, 32'h3000_0010, 8'h5A, 0, 2, M_ACK, 8'h00, 0, 0);
        tbl[1] = mk(8'h52, 32'h3000_0002, 8'h00, 3, 3, M_ACK, 8'hA5, 0, 0);
        tbl[2] = mk(8'h57, 32'h1234_5678, 8'hC3, 0, 1, M_BOTH, 8'h00, 0, 0);
        tbl[3] = mk(8'h52, 32'hDEAD_BEEF, 8'h00, 0, 0, M_NONE, 8'h00, 1, 0);
        tbl[4] = mk(8'h41, 32'h0, 8'h00, 0, 0, M_ACK, 8'h00, 0, 0);
        tbl[5] = mk(8'h57, 32'h3000_0010, 8'h5A, 0, 2, M_ACK, 8'h00, 0, 1);
        tbl[6] = mk(8'h52, 32'h0000_00FF, 8'h00, 0, 0, M_ERR, 8'h77, 0, 0);
        tbl[7] = mk(8'h52, 32'h8000_0001, 8'h00, 0, 0, M_ACK, 8'h3C, 0, 0);
        tbl[8] = mk(8'h57, 32'h0102_0304, 8'h99, 2, TMO - 1, M_ACK, 8'h00, 0, 0);
        tbl[9] = mk(8'h52, 32'hFFFF_FFFE, 8'h00, 1, TMO, M_ACK, 8'h11, 1, 0);

        UART_RX = 1'b1;
        RST = 1'b1;
        repeat (5) @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        check("rst_tx", UART_TX, 1);
        check("rst_cyc", WB_CYC, 0);
        check("rst_stb", WB_STB, 0);
        check("rst_we", WB_WE, 0);
        check("rst_sel", WB_SEL, 0);
        check("rst_addr", WB_ADDR, 0);
        check("rst_wdata", WB_WDATA, 0);
        check("rst_busy", BUSY, 0);

        for (int i = 0; i < 10; i++) run_vec(tbl[i]);

        // Framing error mid-frame returns to idle; the following frame still works.
        clear_mon(mk(8'h57, 0, 0, 0, 1, M_ACK, 0, 0, 0));
        send_byte(8'h57, 1'b1);
        send_byte(8'h30, 1'b1);
        send_byte(8'hAA, 1'b0);
        repeat (2 * CPB) @(negedge CLK);
        check("ferr_idle", BUSY, 0);
        check("ferr_no_cyc", cyc_seen, 0);
        run_vec(mk(8'h57, 32'h0A0B_0C0D, 8'h42, 1, 2, M_ACK, 8'h00, 0, 0));

        // Reset while waiting on the bus: CYC drops on the next edge and no reply is sent.
        clear_mon(mk(8'h52, 0, 0, 0, 0, M_NONE, 0, 0, 0));
        send_byte(8'h52, 1'b1);
        for (int b = 0; b < 4; b++) send_byte(8'h20 + 8'(b), 1'b1);
`ifdef CORTEZ_UART_CSUM_EN
        send_byte(8'h52 ^ 8'h20 ^ 8'h21 ^ 8'h22 ^ 8'h23, 1'b1);
`endif
        for (w = 0; w < 2000 && !WB_CYC; w++) @(negedge CLK);
        check("rst_wait_cyc", 32'(w < 2000), 1);
        repeat (5) @(negedge CLK);
        check("bus_wait_stb", WB_STB, 0);
        RST = 1'b1;
        @(posedge CLK); #1;
        check("rst_cyc_drop", WB_CYC, 0);
        @(negedge CLK);
        RST = 1'b0;
        lows = 0;
        repeat (15 * CPB) begin
            @(negedge CLK);
            if (UART_TX !== 1'b1) lows++;
        end
        check("rst_tx_idle", lows, 0);
        check("rst_no_tx", tx_q.size(), 0);

        for (int i = 0; i < 16; i++) begin
            int r;
            r = $urandom_range(0, 9);
            v.cmd      = (r < 4) ? 8'h57 : (r < 8) ? 8'h52 : 8'($urandom);
            v.addr     = $urandom;
            v.wdata    = 8'($urandom);
            v.stall    = $urandom_range(0, 4);
            v.resp_at  = ($urandom_range(0, 7) == 0) ? TMO + 5 : $urandom_range(0, 8);
            v.mode     = $urandom_range(0, 3);
            v.rdata    = 8'($urandom);
            v.late     = 1'($urandom_range(0, 1));
            v.bad_csum = ($urandom_range(0, 5) == 0);
            run_vec(v);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
